// File: rtl/rvh_l1d_pkg.sv
// rtl/rvh_l1d_pkg.sv - shared L1D constants, MESI encoding and write-arbiter state type
package rvh_l1d_pkg;

  localparam int L1D_WR_ARB_N_REQ = 4;
  localparam int BURST_SIZE       = 8;
  localparam int MEM_DATA_WIDTH   = 64;

  localparam logic [1:0] MESI_M = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } l2_wr_arb_state_e;

endpackage

// File: rtl/rvh_l1d_rr_arb.sv
// rtl/rvh_l1d_rr_arb.sv - combinational round-robin pick, first request at or after ptr
module rvh_l1d_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_req
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // N is a power of two, so the truncating add wraps the search circularly
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/rvh_l1d_l2_wr_arb.sv
// rtl/rvh_l1d_l2_wr_arb.sv - round-robin share of the L2 AW/W port among L1D eviction queues
module rvh_l1d_l2_wr_arb
  import rvh_l1d_pkg::*;
#(
  parameter int N_REQ     = L1D_WR_ARB_N_REQ,
  parameter int AW_W      = 16,
  parameter int DATA_W    = MEM_DATA_WIDTH,
  parameter int BURST_LEN = BURST_SIZE,
  parameter int ID_W      = $clog2(N_REQ),
  parameter int CNT_W     = $clog2(BURST_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_awvalid_i,
  output logic [N_REQ-1:0]         req_awready_o,
  input  logic [N_REQ*AW_W-1:0]    req_aw_i,
  input  logic [N_REQ-1:0]         req_wvalid_i,
  output logic [N_REQ-1:0]         req_wready_o,
  input  logic [N_REQ*DATA_W-1:0]  req_w_i,
  output logic                     l2_awvalid_o,
  input  logic                     l2_awready_i,
  output logic [AW_W-1:0]          l2_aw_o,
  output logic [ID_W-1:0]          l2_awid_o,
  output logic                     l2_wvalid_o,
  input  logic                     l2_wready_i,
  output logic [DATA_W-1:0]        l2_w_o,
  output logic                     l2_wlast_o,
  output logic                     busy_o
);

  l2_wr_arb_state_e state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [N_REQ-1:0] owner_oh_q, owner_oh_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [N_REQ-1:0] win_grant;
  logic [ID_W-1:0]  win_idx;
  logic             win_any;

  logic              owner_awvalid;
  logic              owner_wvalid;
  logic [AW_W-1:0]   owner_aw;
  logic [DATA_W-1:0] owner_w;
  logic              last_beat;

  rvh_l1d_rr_arb #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr_arb (
    .req     (req_awvalid_i),
    .ptr     (rr_ptr_q),
    .grant   (win_grant),
    .idx     (win_idx),
    .any_req (win_any)
  );

  assign owner_awvalid = req_awvalid_i[owner_q];
  assign owner_wvalid  = req_wvalid_i[owner_q];
  assign owner_aw      = req_aw_i[owner_q*AW_W +: AW_W];
  assign owner_w       = req_w_i[owner_q*DATA_W +: DATA_W];
  assign last_beat     = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
  assign busy_o        = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    owner_oh_d    = owner_oh_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    req_awready_o = '0;
    req_wready_o  = '0;
    l2_awvalid_o  = 1'b0;
    l2_aw_o       = '0;
    l2_awid_o     = '0;
    l2_wvalid_o   = 1'b0;
    l2_w_o        = '0;
    l2_wlast_o    = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d    = ADDR;
          owner_d    = win_idx;
          owner_oh_d = win_grant;
        end
      end

      // Grant is held even if the owner drops awvalid; only a handshake releases it
      ADDR: begin
        l2_awvalid_o  = owner_awvalid;
        l2_aw_o       = owner_aw;
        l2_awid_o     = owner_q;
        req_awready_o = owner_oh_q & {N_REQ{l2_awready_i}};
        if (owner_awvalid && l2_awready_i) begin
          if (owner_aw[1:0] == MESI_M) begin
            state_d    = DATA;
            beat_cnt_d = '0;
          end else begin
            state_d  = IDLE;
            rr_ptr_d = owner_q + ID_W'(1);
          end
        end
      end

      DATA: begin
        l2_wvalid_o  = owner_wvalid;
        l2_w_o       = owner_w;
        l2_wlast_o   = owner_wvalid & last_beat;
        req_wready_o = owner_oh_q & {N_REQ{l2_wready_i}};
        if (owner_wvalid && l2_wready_i) begin
          if (last_beat) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = owner_q + ID_W'(1);
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      owner_oh_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_oh_q <= owner_oh_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_rvh_l1d_l2_wr_arb.sv
// tb/tb_rvh_l1d_l2_wr_arb.sv - self-checking bench for rvh_l1d_l2_wr_arb
module tb_rvh_l1d_l2_wr_arb;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int BL = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_awvalid_i;
  logic [N-1:0]   req_awready_o;
  logic [N*AW-1:0] req_aw_i;
  logic [N-1:0]   req_wvalid_i;
  logic [N-1:0]   req_wready_o;
  logic [N*DW-1:0] req_w_i;
  logic           l2_awvalid_o;
  logic           l2_awready_i;
  logic [AW-1:0]  l2_aw_o;
  logic [1:0]     l2_awid_o;
  logic           l2_wvalid_o;
  logic           l2_wready_i;
  logic [DW-1:0]  l2_w_o;
  logic           l2_wlast_o;
  logic           busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rvh_l1d_l2_wr_arb dut (
    .clk           (clk),
    .rst           (rst),
    .req_awvalid_i (req_awvalid_i),
    .req_awready_o (req_awready_o),
    .req_aw_i      (req_aw_i),
    .req_wvalid_i  (req_wvalid_i),
    .req_wready_o  (req_wready_o),
    .req_w_i       (req_w_i),
    .l2_awvalid_o  (l2_awvalid_o),
    .l2_awready_i  (l2_awready_i),
    .l2_aw_o       (l2_aw_o),
    .l2_awid_o     (l2_awid_o),
    .l2_wvalid_o   (l2_wvalid_o),
    .l2_wready_i   (l2_wready_i),
    .l2_w_o        (l2_w_o),
    .l2_wlast_o    (l2_wlast_o),
    .busy_o        (busy_o)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] awv;
    logic       rdy;
    logic       eav;
    logic [1:0] eid;
    logic [3:0] erdy;
    logic       ebusy;
  } vec_t;

  vec_t vt[$];

  // Reference model: which bank holds the port, whether it is streaming a burst
  int m_grant, m_next, m_beats;
  bit m_burst;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [93:0] pack_out();
    return {req_awready_o, req_wready_o, l2_awvalid_o, l2_aw_o, l2_awid_o,
            l2_wvalid_o, l2_w_o, l2_wlast_o, busy_o};
  endfunction

  function automatic logic [15:0] aw_clean(input int b);
    return {14'(b + 5), 2'd1};
  endfunction

  task automatic add_vec(input logic r, input logic [3:0] awv, input logic rdy, input logic eav,
                         input logic [1:0] eid, input logic [3:0] erdy, input logic ebusy);
    vec_t v;
    v = {r, awv, rdy, eav, eid, erdy, ebusy};
    vt.push_back(v);
  endtask

  task automatic model_expect(output logic [93:0] e);
    logic [3:0]  ear, ewr;
    logic        eav, ewv, ewl;
    logic [15:0] eaw;
    logic [1:0]  eid;
    logic [63:0] ew;
    ear = '0; ewr = '0; eav = 0; ewv = 0; ewl = 0; eaw = '0; eid = '0; ew = '0;
    if (m_grant >= 0 && !m_burst) begin
      eav          = req_awvalid_i[m_grant];
      eaw          = req_aw_i[m_grant*AW +: AW];
      eid          = 2'(m_grant);
      ear[m_grant] = l2_awready_i;
    end
    if (m_grant >= 0 && m_burst) begin
      ewv          = req_wvalid_i[m_grant];
      ew           = req_w_i[m_grant*DW +: DW];
      ewr[m_grant] = l2_wready_i;
      ewl          = ewv && (m_beats == BL - 1);
    end
    e = {ear, ewr, eav, eaw, eid, ewv, ew, ewl, (m_grant >= 0)};
  endtask

  task automatic model_step();
    if (!rst) begin
      m_grant = -1; m_burst = 0; m_beats = 0; m_next = 0;
    end else if (m_grant < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_grant < 0 && req_awvalid_i[(m_next + k) % N]) m_grant = (m_next + k) % N;
      end
    end else if (!m_burst) begin
      if (req_awvalid_i[m_grant] && l2_awready_i) begin
        if (req_aw_i[m_grant*AW +: 2] == 2'd3) begin
          m_burst = 1; m_beats = 0;
        end else begin
          m_next = (m_grant + 1) % N; m_grant = -1;
        end
      end
    end else if (req_wvalid_i[m_grant] && l2_wready_i) begin
      m_beats++;
      if (m_beats == BL) begin
        m_next = (m_grant + 1) % N; m_grant = -1; m_burst = 0; m_beats = 0;
      end
    end
  endtask

  task automatic run_dirty(input int bank, input int stall_a, input int stall_b, input int rst_after);
    int k, hs, lasts;
    bit sa, sb, stall, aborted;
    logic [15:0] aw_val;
    k = 0; hs = 0; lasts = 0; sa = 0; sb = 0; aborted = 0;
    aw_val = {14'(16'h0200 + bank), 2'd3};
    req_aw_i[bank*AW +: AW] = aw_val;
    req_awvalid_i = 4'(1 << bank);
    l2_awready_i  = 1'b1;
    req_wvalid_i  = '0;
    l2_wready_i   = 1'b1;
    #1;
    check("dirty_idle_busy", 128'(busy_o), 128'(0));
    tick();
    check("dirty_aw", 128'({l2_awvalid_o, l2_awid_o, l2_aw_o, req_awready_o}),
          128'({1'b1, 2'(bank), aw_val, 4'(1 << bank)}));
    tick();
    req_awvalid_i = '0;
    req_wvalid_i  = 4'hF;
    for (int c = 0; c < 40 && k < BL && !aborted; c++) begin
      if (rst_after >= 0 && k == rst_after) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", 128'(pack_out()), 128'(0));
        aborted = 1;
      end else begin
        for (int b = 0; b < N; b++)
          req_w_i[b*DW +: DW] = (b == bank) ? 64'(k) : {$urandom(), $urandom()};
        stall = (k == stall_a && !sa) || (k == stall_b && !sb);
        if (stall && k == stall_a) sa = 1;
        if (stall && k == stall_b) sb = 1;
        l2_wready_i = !stall;
        #1;
        check($sformatf("dirty_beat%0d", k),
              128'({l2_wvalid_o, l2_w_o, l2_wlast_o, req_wready_o, l2_awvalid_o, req_awready_o}),
              128'({1'b1, 64'(k), (k == BL - 1), (stall ? 4'b0 : 4'(1 << bank)), 1'b0, 4'b0}));
        if (!stall) begin
          hs++;
          if (l2_wlast_o) lasts++;
          k++;
        end
        tick();
      end
    end
    if (!aborted) begin
      check("dirty_handshakes", 128'(hs), 128'(BL));
      check("dirty_wlast_count", 128'(lasts), 128'(1));
      check("dirty_done", 128'({busy_o, l2_wvalid_o}), 128'(0));
    end
    req_wvalid_i = '0;
    l2_wready_i  = 1'b1;
  endtask

  initial begin
    logic [93:0] e;
    vec_t v;

    rst = 1'b0; req_awvalid_i = '0; req_wvalid_i = '0; req_w_i = '0;
    l2_awready_i = 1'b1; l2_wready_i = 1'b1;
    for (int b = 0; b < N; b++) req_aw_i[b*AW +: AW] = aw_clean(b);
    tick();
    tick();

    // rst, awvalid, awready | exp awvalid, awid, awready vector, busy
    add_vec(1, 4'b0000, 1, 0, 0, 4'b0000, 0);
    add_vec(1, 4'b0100, 1, 0, 0, 4'b0000, 0);
    add_vec(1, 4'b0100, 1, 1, 2, 4'b0100, 1);
    add_vec(1, 4'b0000, 1, 0, 0, 4'b0000, 0);
    add_vec(0, 4'b0000, 1, 0, 0, 4'b0000, 0);
    add_vec(1, 4'b1111, 1, 0, 0, 4'b0000, 0);
    add_vec(1, 4'b1111, 1, 1, 0, 4'b0001, 1);
    add_vec(1, 4'b1111, 1, 0, 0, 4'b0000, 0);
    add_vec(1, 4'b1111, 1, 1, 1, 4'b0010, 1);
    add_vec(1, 4'b1111, 1, 0, 0, 4'b0000, 0);
    add_vec(1, 4'b1111, 1, 1, 2, 4'b0100, 1);
    add_vec(1, 4'b1111, 1, 0, 0, 4'b0000, 0);
    add_vec(1, 4'b1111, 1, 1, 3, 4'b1000, 1);
    add_vec(1, 4'b1111, 1, 0, 0, 4'b0000, 0);
    add_vec(1, 4'b1111, 1, 1, 0, 4'b0001, 1);
    add_vec(1, 4'b1001, 0, 0, 0, 4'b0000, 0);
    for (int i = 0; i < 5; i++) add_vec(1, 4'b1001, 0, 1, 3, 4'b0000, 1);
    add_vec(1, 4'b1001, 1, 1, 3, 4'b1000, 1);
    add_vec(1, 4'b1001, 1, 0, 0, 4'b0000, 0);
    add_vec(1, 4'b1001, 1, 1, 0, 4'b0001, 1);
    add_vec(1, 4'b0000, 1, 0, 0, 4'b0000, 0);

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      rst = v.rst; req_awvalid_i = v.awv; l2_awready_i = v.rdy;
      #1;
      check($sformatf("tbl_row%0d", i),
            128'({l2_awvalid_o, l2_awid_o, req_awready_o, busy_o, l2_aw_o, l2_wvalid_o, req_wready_o}),
            128'({v.eav, v.eid, v.erdy, v.ebusy, (v.ebusy ? aw_clean(int'(v.eid)) : 16'h0), 1'b0, 4'b0}));
      tick();
    end

    run_dirty(0, -1, -1, -1);
    run_dirty(2, 3, 5, -1);
    run_dirty(3, -1, -1, 4);

    req_aw_i[1*AW +: AW] = aw_clean(1);
    req_awvalid_i = 4'b0010;
    #1;
    check("post_rst_idle", 128'({busy_o, l2_awvalid_o}), 128'(0));
    tick();
    check("post_rst_grant", 128'({l2_awvalid_o, l2_awid_o, req_awready_o}), 128'({1'b1, 2'd1, 4'b0010}));
    tick();
    req_awvalid_i = '0;

    rst = 1'b0;
    tick();
    m_grant = -1; m_burst = 0; m_beats = 0; m_next = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      req_awvalid_i = 4'($urandom());
      for (int b = 0; b < N; b++) begin
        req_aw_i[b*AW +: AW] = 16'($urandom());
        req_w_i[b*DW +: DW]  = {$urandom(), $urandom()};
        req_wvalid_i[b]      = ($urandom_range(0, 3) != 0);
      end
      l2_awready_i = ($urandom_range(0, 9) < 6);
      l2_wready_i  = ($urandom_range(0, 9) < 7);
      #1;
      model_expect(e);
      check($sformatf("rand_cycle%0d", c), 128'(pack_out()), 128'(e));
      @(posedge clk);
      model_step();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvh_l1d_l2_wr_arb.md
Name: rvh_l1d_l2_wr_arb

Overview:
Round-robin arbiter that shares the single L2 write-request port (AW and W channels) between the eviction write queues of N_REQ L1D banks. It grants one bank at a time and holds that grant through the AW handshake. For a dirty (Modified) line it also holds the grant through the full 8-beat W burst, then releases. It sits between the per-bank eviction write queues and the L2 request interface.

Parameters:
N_REQ, 4, number of requesting banks (power of two, 2..8)
AW_W, 16, AW payload width: [15:2] line address, [1:0] MESI state
DATA_W, 64, W beat width (MEM_DATA_WIDTH)
BURST_LEN, 8, W beats per dirty line (512/DATA_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
req_awvalid_i  in  N_REQ  per-bank AW valid
req_awready_o  out  N_REQ  per-bank AW ready
req_aw_i  in  N_REQ*AW_W  per-bank AW payload; bank i at [i*AW_W +: AW_W]
req_wvalid_i  in  N_REQ  per-bank W valid
req_wready_o  out  N_REQ  per-bank W ready
req_w_i  in  N_REQ*DATA_W  per-bank W beat; bank i at [i*DATA_W +: DATA_W]
l2_awvalid_o  out  1  L2 AW valid
l2_awready_i  in  1  L2 AW ready
l2_aw_o  out  AW_W  L2 AW payload
l2_awid_o  out  $clog2(N_REQ)  index of owning bank
l2_wvalid_o  out  1  L2 W valid
l2_wready_i  in  1  L2 W ready
l2_w_o  out  DATA_W  L2 W beat
l2_wlast_o  out  1  last beat of burst
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst==0 at posedge clk), including mid-burst: state=IDLE, owner=0, rr_ptr=0, beat_cnt=0. All outputs 0 while in IDLE, since all outputs decode from state.
- State machine, states IDLE, ADDR, DATA:
  - IDLE: if any req_awvalid_i, pick winner = first set bit at or after rr_ptr (circular), latch owner, go to ADDR. No outputs asserted in IDLE, so the first L2 awvalid appears 1 cycle after a request is seen.
  - ADDR: l2_awvalid_o = req_awvalid_i[owner]; l2_aw_o = req_aw_i[owner]; l2_awid_o = owner; req_awready_o[owner] = l2_awready_i, all other bits 0.
    - On handshake (l2_awvalid_o & l2_awready_i): if l2_aw_o[1:0]==MESI_M (2'd3), go to DATA with beat_cnt=0. Otherwise go to IDLE with rr_ptr=owner+1 (mod N_REQ).
    - If the owner deasserts awvalid, stay in ADDR holding the grant; there is no timeout.
  - DATA: l2_wvalid_o = req_wvalid_i[owner]; l2_w_o = req_w_i[owner]; req_wready_o[owner] = l2_wready_i, all others 0.
    - beat_cnt increments on each W handshake only.
    - l2_wlast_o = l2_wvalid_o & (beat_cnt==BURST_LEN-1).
    - On the last-beat handshake: go to IDLE, beat_cnt=0, rr_ptr=owner+1.
    - Stalls (wready=0 or wvalid=0) hold beat_cnt and the beat data unchanged.
- Non-owner valids are ignored. Every W-related output is 0 outside DATA, and l2_awvalid_o is 0 outside ADDR.
- l2_aw_o, l2_w_o and l2_awid_o are 0 when their channel is not active.
- beat_cnt is $clog2(BURST_LEN) bits, with no wrap beyond BURST_LEN-1. rr_ptr wraps modulo N_REQ.
- Throughput: a clean line costs a minimum of 2 cycles (IDLE+ADDR). A dirty line costs a minimum of 2+BURST_LEN cycles.
- Fairness: no bank waits more than N_REQ-1 grants.

Decomposition:
- Shared package rvh_l1d_pkg holds:
  - L1D_WR_ARB_N_REQ
  - BURST_SIZE (8)
  - MEM_DATA_WIDTH (64)
  - MESI encoding localparam MESI_M=2'd3
  - state enum {IDLE, ADDR, DATA}
- One sub-module: rvh_l1d_rr_arb. It is a combinational round-robin priority pick: inputs are the N_REQ request vector and rr_ptr; outputs are a one-hot grant plus a binary index and any_req.
- Pointer, state and counter registers stay in the top module.

Test Plan:
- Single clean request: bank 2 awvalid with aw[1:0]=2'd1 and l2_awready=1 -> l2_awvalid high in cycle 2 with awid=2; back to IDLE in cycle 3; wvalid never asserted.
- Single dirty request: bank 0 with aw[1:0]=2'd3 and wready=1 constantly, beats 0..7 = 64'h0..64'h7 -> 8 consecutive W beats on L2 in order; wlast only on beat 7; busy_o falls after beat 7.
- All 4 banks request clean lines continuously, starting rr_ptr=0 -> awid sequence 0,1,2,3,0; exactly one req_awready_o bit set per handshake.
- Dirty burst with back-pressure: l2_wready low on beats 3 and 5 -> beat_cnt holds; exactly 8 handshakes; wlast coincides with the 8th handshake; other banks' readies stay 0 throughout.
- Reset mid-burst: drop rst after 4 beats -> next cycle all outputs 0, state IDLE; a new request from bank 1 is granted with awid=1 (rr_ptr=0).
- AW stall: bank 3 granted with l2_awready=0 for 5 cycles while bank 0 also requests -> l2_awid stays 3 until handshake; bank 0 is granted next.
